gpr_debug_ctrl: RTL and testbench
=================================

// Module: gpr_debug_ctrl
// PURPOSE
// - Sequences debug-port access to the 32-entry RV64 GPR file: halts core, reads/writes one GPR, resumes core.
// - Sits between debug transport (req/rsp valid-ready) and the regfile's dedicated debug read/write port.
// - Guarantees no debug GPR write collides with core writeback: access only while core_halted=1.
// PARAMETERS
// - ARCH_WIDTH    64    GPR data width
// - HALT_TIMEOUT  255   max cycles in HALT waiting for core_halted before error response (>=1)
// PORTS
// - clk            in   1           clock, all state on rising edge
// - rst_n          in   1           asynchronous active-low reset
// - dbg_req_valid  in   1           debug request valid
// - dbg_req_ready  out  1           high only in IDLE
// - dbg_req_write  in   1           1=write GPR, 0=read GPR
// - dbg_req_addr   in   5           GPR index 0..31
// - dbg_req_wdata  in   ARCH_WIDTH  write data
// - dbg_rsp_valid  out  1           response valid, held until dbg_rsp_ready
// - dbg_rsp_ready  in   1           response accept
// - dbg_rsp_rdata  out  ARCH_WIDTH  read data (0 for writes and errors)
// - dbg_rsp_err    out  1           1=halt timeout, no access performed
// - core_halt_req  out  1           registered halt request to core
// - core_halted    in   1           core is stopped at instruction boundary
// - rf_dbg_raddr   out  5           regfile debug read index (= captured addr)
// - rf_dbg_rdata   in   ARCH_WIDTH  regfile combinational read data
// - rf_dbg_we      out  1           regfile debug write enable, single-cycle pulse
// - rf_dbg_waddr   out  5           = captured addr
// - rf_dbg_wdata   out  ARCH_WIDTH  = captured wdata
// - busy           out  1           state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; all outputs 0 except dbg_req_ready=1; captured addr/wdata/rdata=0; timer=0.
// - FSM states IDLE, HALT, ACCESS, RESP, RESUME; one transition max per cycle.
// - IDLE: on valid&&ready capture write/addr/wdata; next cycle state=HALT, core_halt_req=1.
// - HALT: halt_req held; core_halted=1 -> ACCESS; timer counts cycles in HALT, at HALT_TIMEOUT -> RESP with err=1, halt_req=0.
// - ACCESS (exactly 1 cycle, halt_req=1): write: rf_dbg_we=1 unless addr==0 (x0 write dropped, err=0);
//   read: rsp_rdata <= rf_dbg_rdata (x0 returns regfile value, expected 0). -> RESP.
// - RESP: rsp_valid=1, rdata/err stable; on rsp_ready: non-error -> RESUME with halt_req=0; error -> IDLE.
// - RESUME: halt_req=0; core_halted=0 -> IDLE (same cycle low: leave next edge).
// - Latency (core already halted): req accepted cycle N; HALT N+1; ACCESS N+2; rsp_valid N+3.
// - New requests ignored (ready=0) outside IDLE; no queuing. rsp_valid never drops without rsp_ready.
// - core_halted asserting while not in HALT is ignored; dropping during ACCESS is a core protocol violation (assertion).
// - Timer width = $clog2(HALT_TIMEOUT+1); cleared on HALT entry; never wraps.
// - Reset mid-operation: aborts immediately, in-flight write lost if not yet pulsed, halt_req released.
// CONFIGURATION
// - GPR_DEBUG_TIMEOUT_EN defined: timer and error path as above.
// - Not defined: no timer; HALT waits indefinitely; dbg_rsp_err tied 0.
// STRUCTURE
// - Package gpr_dbg_pkg: state enum gpr_dbg_state_t, GPR_ADDR_W=5, NUM_GPR=32, ABI index constants (ZERO=0, RA=1, SP=2, ... T6=31).
// - Sub-module gpr_dbg_halt_timer (clear/enable/expired) instantiated only under GPR_DEBUG_TIMEOUT_EN.
// TESTING
// - Read a0: regfile x10=64'hDEAD_BEEF_0000_0001, core_halted high 2 cycles after halt_req -> rsp rdata=that value, err=0, halt_req drops after rsp.
// - Write sp=64'h8000_1000 -> exactly one rf_dbg_we pulse, waddr=2, wdata matches; rsp rdata=0, err=0.
// - Write x0=64'hFFFF -> no rf_dbg_we pulse; rsp err=0.
// - Timeout (macro on, HALT_TIMEOUT=8): core_halted stuck 0 -> rsp at HALT+8 cycles, err=1, no access.
// - Backpressure: rsp_ready low 5 cycles -> rsp_valid/rdata stable, req_ready=0, second req not accepted until IDLE.
// - rst_n low during ACCESS/RESP -> same cycle halt_req=0, rsp_valid=0, we=0; req_ready=1 after release.

Source files
------------

// File: rtl/gpr_dbg_pkg.sv
// Shared types and constants for the GPR debug access controller:
// FSM state encoding, GPR file geometry and RISC-V ABI register indices.
package gpr_dbg_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int NUM_GPR    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_RESUME = 3'd4
  } gpr_dbg_state_t;

  // ABI names for the integer register file
  localparam logic [GPR_ADDR_W-1:0] ZERO = 5'd0;
  localparam logic [GPR_ADDR_W-1:0] RA   = 5'd1;
  localparam logic [GPR_ADDR_W-1:0] SP   = 5'd2;
  localparam logic [GPR_ADDR_W-1:0] GP   = 5'd3;
  localparam logic [GPR_ADDR_W-1:0] TP   = 5'd4;
  localparam logic [GPR_ADDR_W-1:0] T0   = 5'd5;
  localparam logic [GPR_ADDR_W-1:0] T1   = 5'd6;
  localparam logic [GPR_ADDR_W-1:0] T2   = 5'd7;
  localparam logic [GPR_ADDR_W-1:0] S0   = 5'd8;
  localparam logic [GPR_ADDR_W-1:0] S1   = 5'd9;
  localparam logic [GPR_ADDR_W-1:0] A0   = 5'd10;
  localparam logic [GPR_ADDR_W-1:0] A1   = 5'd11;
  localparam logic [GPR_ADDR_W-1:0] A2   = 5'd12;
  localparam logic [GPR_ADDR_W-1:0] A3   = 5'd13;
  localparam logic [GPR_ADDR_W-1:0] A4   = 5'd14;
  localparam logic [GPR_ADDR_W-1:0] A5   = 5'd15;
  localparam logic [GPR_ADDR_W-1:0] A6   = 5'd16;
  localparam logic [GPR_ADDR_W-1:0] A7   = 5'd17;
  localparam logic [GPR_ADDR_W-1:0] S2   = 5'd18;
  localparam logic [GPR_ADDR_W-1:0] S3   = 5'd19;
  localparam logic [GPR_ADDR_W-1:0] S4   = 5'd20;
  localparam logic [GPR_ADDR_W-1:0] S5   = 5'd21;
  localparam logic [GPR_ADDR_W-1:0] S6   = 5'd22;
  localparam logic [GPR_ADDR_W-1:0] S7   = 5'd23;
  localparam logic [GPR_ADDR_W-1:0] S8   = 5'd24;
  localparam logic [GPR_ADDR_W-1:0] S9   = 5'd25;
  localparam logic [GPR_ADDR_W-1:0] S10  = 5'd26;
  localparam logic [GPR_ADDR_W-1:0] S11  = 5'd27;
  localparam logic [GPR_ADDR_W-1:0] T3   = 5'd28;
  localparam logic [GPR_ADDR_W-1:0] T4   = 5'd29;
  localparam logic [GPR_ADDR_W-1:0] T5   = 5'd30;
  localparam logic [GPR_ADDR_W-1:0] T6   = 5'd31;

endpackage

// File: rtl/gpr_dbg_halt_timer.sv
// Halt-wait timer: counts cycles while enabled, saturates (never wraps),
// and flags expiry on the HALT_TIMEOUT-th enabled cycle so the controller
// spends exactly HALT_TIMEOUT cycles waiting before giving up.
module gpr_dbg_halt_timer #(
  parameter int HALT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_MAX  = TW'(HALT_TIMEOUT);
  localparam logic [TW-1:0] CNT_LAST = TW'(HALT_TIMEOUT - 1);

  logic [TW-1:0] count_q;

  // Saturating cycle counter, cleared whenever the controller is not waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry seen during the last permitted waiting cycle
  always_comb begin
    expired = enable && (count_q >= CNT_LAST);
  end

endmodule

// File: rtl/gpr_debug_ctrl.sv
// Debug-port sequencer for the 32-entry RV64 GPR file: halt core, do one
// read or write through the regfile debug port, respond, resume core.
// Optional halt timeout path enabled by defining GPR_DEBUG_TIMEOUT_EN.
//
// Handshake rule (both req and rsp channels): a transfer happens on a rising
// edge where valid && ready are both 1; valid, once raised, is held with its
// payload stable until that edge.
module gpr_debug_ctrl
  import gpr_dbg_pkg::*;
#(
  parameter int ARCH_WIDTH   = 64,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [GPR_ADDR_W-1:0] dbg_req_addr,
  input  logic [ARCH_WIDTH-1:0] dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  input  logic                  dbg_rsp_ready,
  output logic [ARCH_WIDTH-1:0] dbg_rsp_rdata,
  output logic                  dbg_rsp_err,
  output logic                  core_halt_req,
  input  logic                  core_halted,
  output logic [GPR_ADDR_W-1:0] rf_dbg_raddr,
  input  logic [ARCH_WIDTH-1:0] rf_dbg_rdata,
  output logic                  rf_dbg_we,
  output logic [GPR_ADDR_W-1:0] rf_dbg_waddr,
  output logic [ARCH_WIDTH-1:0] rf_dbg_wdata,
  output logic                  busy
);

  if (HALT_TIMEOUT < 1) begin : g_bad_timeout
    $error("HALT_TIMEOUT must be at least 1");
  end

  gpr_dbg_state_t state_q, state_d;

  logic                  wr_q;
  logic [GPR_ADDR_W-1:0] addr_q;
  logic [ARCH_WIDTH-1:0] wdata_q;
  logic [ARCH_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timer_expired;
  logic                  req_fire;

  assign req_fire = dbg_req_valid && (state_q == ST_IDLE);

`ifdef GPR_DEBUG_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (state_q == ST_HALT) && !core_halted && timer_expired;

  gpr_dbg_halt_timer #(
    .HALT_TIMEOUT (HALT_TIMEOUT)
  ) u_halt_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ST_HALT),
    .enable  (state_q == ST_HALT),
    .expired (timer_expired)
  );

  // Error flag: cleared on accept, set when the halt wait gives up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (req_fire) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timer_expired = 1'b0;
  assign err_q         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture and read-data latch; rdata cleared on accept so writes
  // and errors answer with zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (req_fire) begin
      wr_q    <= dbg_req_write;
      addr_q  <= dbg_req_addr;
      wdata_q <= dbg_req_wdata;
      rdata_q <= '0;
    end else if ((state_q == ST_ACCESS) && !wr_q) begin
      rdata_q <= rf_dbg_rdata;
    end
  end

  // Next-state logic; core_halted is only looked at in HALT and RESUME
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dbg_req_valid) state_d = ST_HALT;
      ST_HALT: begin
        if (core_halted)        state_d = ST_ACCESS;
        else if (timer_expired) state_d = ST_RESP;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (dbg_rsp_ready) state_d = err_q ? ST_IDLE : ST_RESUME;
      ST_RESUME: if (!core_halted)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state so reset clears them at once
  always_comb begin
    dbg_req_ready = (state_q == ST_IDLE);
    busy          = (state_q != ST_IDLE);
    dbg_rsp_valid = (state_q == ST_RESP);
    core_halt_req = (state_q == ST_HALT) || (state_q == ST_ACCESS) ||
                    ((state_q == ST_RESP) && !err_q);
    rf_dbg_we     = (state_q == ST_ACCESS) && wr_q && (addr_q != ZERO);
    dbg_rsp_rdata = rdata_q;
    dbg_rsp_err   = err_q;
    rf_dbg_raddr  = addr_q;
    rf_dbg_waddr  = addr_q;
    rf_dbg_wdata  = wdata_q;
  end

  // The core must stay stopped for the whole access cycle
  a_halted_in_access: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == ST_ACCESS) |-> core_halted
  );

endmodule

// File: tb/tb_gpr_debug_ctrl.sv
// Self-checking bench for gpr_debug_ctrl: directed table, backpressure,
// optional halt timeout (GPR_DEBUG_TIMEOUT_EN), randomized traffic against a
// register-array reference model, and asynchronous reset mid-operation.
module tb_gpr_debug_ctrl;
  import gpr_dbg_pkg::*;

  localparam int W  = 64;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          dbg_req_valid = 1'b0, dbg_req_write = 1'b0;
  logic [4:0]    dbg_req_addr = '0;
  logic [W-1:0]  dbg_req_wdata = '0;
  logic          dbg_rsp_ready = 1'b0;
  logic          core_halted = 1'b0;
  logic          dbg_req_ready, dbg_rsp_valid, dbg_rsp_err, core_halt_req;
  logic          rf_dbg_we, busy;
  logic [W-1:0]  dbg_rsp_rdata, rf_dbg_rdata, rf_dbg_wdata;
  logic [4:0]    rf_dbg_raddr, rf_dbg_waddr;

  gpr_debug_ctrl #(.ARCH_WIDTH(W), .HALT_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .core_halt_req(core_halt_req), .core_halted(core_halted),
    .rf_dbg_raddr(rf_dbg_raddr), .rf_dbg_rdata(rf_dbg_rdata),
    .rf_dbg_we(rf_dbg_we), .rf_dbg_waddr(rf_dbg_waddr),
    .rf_dbg_wdata(rf_dbg_wdata), .busy(busy)
  );

  // ---------------- environment: regfile + core ----------------
  logic [W-1:0] rf  [32];   // regfile as written by the DUT
  logic [W-1:0] mem [32];   // reference model of architectural GPR contents
  int           we_cnt;
  logic [4:0]   last_waddr;
  logic [W-1:0] last_wdata;
  int           halt_dly = 0, rel_dly = 1;
  bit           core_stuck = 1'b0, poke = 1'b0;
  int           hcnt = 0, rcnt = 0;
  int           tests = 0, fails = 0;

  assign rf_dbg_rdata = rf[rf_dbg_raddr];

  // Regfile write port and pulse counter
  always @(negedge clk) begin
    if (rst_n && rf_dbg_we) begin
      we_cnt++;
      last_waddr = rf_dbg_waddr;
      last_wdata = rf_dbg_wdata;
      if (rf_dbg_waddr != 5'd0) rf[rf_dbg_waddr] = rf_dbg_wdata;
    end
  end

  // Core: stops halt_dly cycles after halt_req, restarts rel_dly after release
  always @(negedge clk) begin
    if (!rst_n) begin
      core_halted = 1'b0; hcnt = 0; rcnt = 0;
    end else if (core_halt_req) begin
      rcnt = 0;
      if (!core_halted && !core_stuck) begin
        if (hcnt >= halt_dly) core_halted = 1'b1;
        else hcnt++;
      end
    end else begin
      hcnt = 0;
      if (core_halted) begin
        if (rcnt >= rel_dly) core_halted = 1'b0;
        else rcnt++;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input logic wr, input logic [4:0] addr, input logic [W-1:0] wd,
                        input int hdly, input int rdly,
                        output logic [W-1:0] rdata, output logic err, output int lat,
                        output bit stable, output logic halt_in_rsp,
                        output logic halt_after, output bit tmo);
    int n;
    tmo = 1'b0; stable = 1'b1; rdata = '0; err = 1'b0;
    halt_in_rsp = 1'b0; halt_after = 1'b0;
    @(negedge clk);
    halt_dly = hdly; we_cnt = 0;
    dbg_req_valid = 1'b1; dbg_req_write = wr; dbg_req_addr = addr; dbg_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    lat = 1;
    while (!dbg_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!dbg_rsp_valid) begin
      tmo = 1'b1;
      return;
    end
    rdata = dbg_rsp_rdata; err = dbg_rsp_err; halt_in_rsp = core_halt_req;
    for (int i = 0; i < rdly; i++) begin
      if (poke && i == 0) begin
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1;
        dbg_req_addr = 5'd5; dbg_req_wdata = '1;
      end
      @(negedge clk);
      if (!dbg_rsp_valid || dbg_rsp_rdata !== rdata || dbg_rsp_err !== err ||
          dbg_req_ready !== 1'b0) stable = 1'b0;
    end
    dbg_req_valid = 1'b0; dbg_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dbg_rsp_ready = 1'b0;
    halt_after = core_halt_req;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) tmo = 1'b1;
  endtask

  // Run one transaction and compare every observable against expectations
  task automatic run_chk(input string tag, input logic wr, input logic [4:0] addr,
                         input logic [W-1:0] wd, input int hdly, input int rdly,
                         input logic [W-1:0] exp_rdata, input logic exp_err,
                         input int exp_we, input int exp_lat);
    logic [W-1:0] rdata; logic err, hin, haft; int lat; bit stable, tmo;
    do_txn(wr, addr, wd, hdly, rdly, rdata, err, lat, stable, hin, haft, tmo);
    chk({tag, "_no_timeout"}, W'(tmo), W'(0));
    if (tmo) return;
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_err"}, W'(err), W'(exp_err));
    chk({tag, "_latency"}, W'(lat), W'(exp_lat));
    chk({tag, "_we_pulses"}, W'(we_cnt), W'(exp_we));
    chk({tag, "_halt_in_rsp"}, W'(hin), W'(!exp_err));
    chk({tag, "_halt_after_rsp"}, W'(haft), W'(0));
    if (exp_we == 1) begin
      chk({tag, "_waddr"}, W'(last_waddr), W'(addr));
      chk({tag, "_wdata"}, last_wdata, wd);
    end
    if (rdly > 0) chk({tag, "_rsp_stable"}, W'(stable), W'(1));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         wr;
    logic [4:0]   addr;
    logic [W-1:0] wdata;
    int           hdly;
    int           rdly;
    logic [W-1:0] exp_rdata;
    int           exp_we;
  } vec_t;

  vec_t tbl [7];

  initial begin : main
    logic [W-1:0] exp_rd;
    logic         wr;
    logic [4:0]   addr;
    logic [W-1:0] wd;
    int           hd, rd;

    for (int i = 0; i < 32; i++) begin
      rf[i]  = (i == 0) ? '0 : (64'h1111_0000_0000_0000 + W'(i));
      mem[i] = rf[i];
    end
    rf[10] = 64'hDEAD_BEEF_0000_0001; mem[10] = rf[10];
    we_cnt = 0;

    tbl[0] = '{1'b0, A0,   '0,                    2, 0, 64'hDEAD_BEEF_0000_0001, 0};
    tbl[1] = '{1'b1, SP,   64'h8000_1000,         0, 1, '0,                      1};
    tbl[2] = '{1'b1, ZERO, 64'hFFFF,              1, 0, '0,                      0};
    tbl[3] = '{1'b0, SP,   '0,                    0, 0, 64'h8000_1000,           0};
    tbl[4] = '{1'b0, ZERO, '0,                    1, 1, '0,                      0};
    tbl[5] = '{1'b1, T6,   64'h1234_5678_9ABC_DEF0, 3, 2, '0,                    1};
    tbl[6] = '{1'b0, T6,   '0,                    0, 3, 64'h1234_5678_9ABC_DEF0, 0};

    // Reset values
    #12;
    chk("rst_req_ready", W'(dbg_req_ready), W'(1));
    chk("rst_rsp_valid", W'(dbg_rsp_valid), W'(0));
    chk("rst_halt_req",  W'(core_halt_req), W'(0));
    chk("rst_we",        W'(rf_dbg_we),     W'(0));
    chk("rst_busy",      W'(busy),          W'(0));
    chk("rst_rdata",     dbg_rsp_rdata,     '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_chk($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
              tbl[i].hdly, tbl[i].rdly, tbl[i].exp_rdata, 1'b0,
              tbl[i].exp_we, 3 + tbl[i].hdly);
      if (tbl[i].wr && tbl[i].addr != 5'd0) mem[tbl[i].addr] = tbl[i].wdata;
    end

    // Backpressure with a competing request that must not be taken
    poke = 1'b1;
    run_chk("bp", 1'b0, RA, '0, 1, 5, mem[1], 1'b0, 0, 4);
    poke = 1'b0;
    run_chk("bp_after", 1'b0, T0, '0, 0, 0, mem[5], 1'b0, 0, 3);

`ifdef GPR_DEBUG_TIMEOUT_EN
    core_stuck = 1'b1;
    run_chk("timeout", 1'b1, T2, 64'hABCD, 0, 2, '0, 1'b1, 0, 1 + TO);
    core_stuck = 1'b0;
    run_chk("timeout_after", 1'b0, T2, '0, 0, 0, mem[7], 1'b0, 0, 3);
`endif

    // Randomized traffic against the reference array
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      hd = $urandom_range(0, 4);
      rd = $urandom_range(0, 3);
      rel_dly = $urandom_range(0, 3);
      exp_rd = wr ? '0 : mem[addr];
      run_chk($sformatf("rnd%0d", k), wr, addr, wd, hd, rd, exp_rd, 1'b0,
              (wr && addr != 5'd0) ? 1 : 0, 3 + hd);
      if (wr && addr != 5'd0) mem[addr] = wd;
    end
    rel_dly = 1;

    // Reset during ACCESS: write must be lost, outputs drop at once
    @(negedge clk);
    halt_dly = 0; we_cnt = 0;
    dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = GP; dbg_req_wdata = 64'hAAAA;
    @(posedge clk);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstacc_in_access_we", W'(rf_dbg_we), W'(1));
    rst_n = 1'b0;
    #1;
    chk("rstacc_halt_req",  W'(core_halt_req), W'(0));
    chk("rstacc_we",        W'(rf_dbg_we),     W'(0));
    chk("rstacc_rsp_valid", W'(dbg_rsp_valid), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstacc_req_ready", W'(dbg_req_ready), W'(1));
    chk("rstacc_we_pulses", W'(we_cnt),        W'(0));

    // Reset during RESP
    dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = TP;
    @(posedge clk);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    for (int n = 0; n < 20 && !dbg_rsp_valid; n++) @(negedge clk);
    chk("rstrsp_reached_resp", W'(dbg_rsp_valid), W'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstrsp_rsp_valid", W'(dbg_rsp_valid), W'(0));
    chk("rstrsp_halt_req",  W'(core_halt_req), W'(0));
    chk("rstrsp_rdata",     dbg_rsp_rdata,     '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrsp_req_ready", W'(dbg_req_ready), W'(1));

    // GP must still hold its old value after the aborted write
    run_chk("post_rst", 1'b0, GP, '0, 0, 0, mem[3], 1'b0, 0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
